// File: rtl/spu_fetch_unit.sv
// spu_fetch_unit: in-order 64-bit pair fetch into a fetch queue, valid/ready to decode, branch redirect with stale-response discard.
// Optional feature macro FETCH_PERF_CNT_EN adds saturating perf_pairs / perf_redirects counters.
module spu_fetch_unit #(
  parameter int unsigned FQ_DEPTH  = 4,
  parameter int unsigned MAX_OUTST = 4,
  parameter logic [7:0]  RESET_PC  = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        halt,
  input  logic        branch_is_taken,
  input  logic [7:0]  program_counter_wb,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [63:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr0,
  output logic [31:0] out_instr1,
  output logic [1:0]  out_slot_vld,
  output logic [7:0]  out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] perf_pairs,
  output logic [15:0] perf_redirects
`endif
);

  localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 1;
  localparam logic [SW-1:0] FQ_DEPTH_S  = SW'(FQ_DEPTH);
  localparam logic [CW-1:0] MAX_OUTST_C = CW'(MAX_OUTST);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] fq_count_q, fq_count_d;
  logic [PW-1:0] fq_rd_q, fq_rd_d;
  logic [PW-1:0] fq_wr_q, fq_wr_d;
  logic [PW-1:0] tag_rd_q, tag_rd_d;
  logic [PW-1:0] tag_wr_q, tag_wr_d;

  logic [63:0] fq_data_q [FQ_DEPTH];
  logic [7:0]  fq_pc_q   [FQ_DEPTH];
  logic [1:0]  fq_slot_q [FQ_DEPTH];
  // fetch_pc of each outstanding request, in issue order; odd bit marks a first fetch to an odd target
  logic [7:0]  tag_pc_q  [FQ_DEPTH];

  logic       redirect;
  logic       issue;
  logic       resp;
  logic       push;
  logic       pop;
  logic       room;
  logic       fq_nonempty;
  logic [7:0] fetch_addr;
  logic [7:0] resp_tag;

  assign fetch_addr  = {fetch_pc_q[7:1], 1'b0};
  assign redirect    = branch_is_taken && (state_q != S_IDLE);
  assign issue       = imem_req && imem_gnt;
  assign resp        = imem_rvalid && (outst_q != '0);
  assign resp_tag    = tag_pc_q[tag_rd_q];
  assign push        = resp && (discard_q == '0) && !redirect;
  assign pop         = out_valid && out_ready;
  assign fq_nonempty = (fq_count_q != '0);
  assign room        = (({1'b0, outst_q} + {1'b0, fq_count_q}) < FQ_DEPTH_S) &&
                       (outst_q < MAX_OUTST_C);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_RUN;
      S_RUN:    if (halt) state_d = S_HALTED;
      S_HALTED: if (!halt) state_d = S_RUN;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state_q == S_RUN) && !halt && room;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (state_q == S_IDLE) begin
      if (start) fetch_pc_d = RESET_PC;
    end else if (redirect) begin
      fetch_pc_d = program_counter_wb;
    end else if (issue) begin
      fetch_pc_d = fetch_addr + 8'd2;
    end

    outst_d = outst_q + CW'(issue) - CW'(resp);

    // everything still in flight after this cycle belongs to the old path
    discard_d = discard_q;
    if (redirect) begin
      discard_d = outst_d;
    end else if (resp && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end

    tag_wr_d = tag_wr_q + PW'(issue);
    tag_rd_d = tag_rd_q + PW'(resp);
  end

  always_comb begin
    fq_count_d = fq_count_q;
    fq_rd_d    = fq_rd_q;
    fq_wr_d    = fq_wr_q;
    if (redirect) begin
      fq_count_d = '0;
      fq_rd_d    = fq_wr_q;
    end else begin
      fq_count_d = fq_count_q + CW'(push) - CW'(pop);
      fq_wr_d    = fq_wr_q + PW'(push);
      fq_rd_d    = fq_rd_q + PW'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= 8'd0;
      outst_q    <= '0;
      discard_q  <= '0;
      fq_count_q <= '0;
      fq_rd_q    <= '0;
      fq_wr_q    <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      discard_q  <= discard_d;
      fq_count_q <= fq_count_d;
      fq_rd_q    <= fq_rd_d;
      fq_wr_q    <= fq_wr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fq_data_q[fq_wr_q] <= imem_rdata;
      fq_pc_q[fq_wr_q]   <= {resp_tag[7:1], 1'b0};
      fq_slot_q[fq_wr_q] <= resp_tag[0] ? 2'b01 : 2'b11;
    end
    if (issue) begin
      tag_pc_q[tag_wr_q] <= fetch_pc_q;
    end
  end

  assign imem_addr    = fetch_addr;
  assign out_valid    = fq_nonempty && !branch_is_taken;
  // head fields read as zero when the queue is empty so outputs are clean out of reset
  assign out_instr0   = fq_nonempty ? fq_data_q[fq_rd_q][31:0]  : 32'd0;
  assign out_instr1   = fq_nonempty ? fq_data_q[fq_rd_q][63:32] : 32'd0;
  assign out_pc       = fq_nonempty ? fq_pc_q[fq_rd_q]          : 8'd0;
  assign out_slot_vld = fq_nonempty ? fq_slot_q[fq_rd_q]        : 2'b00;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_pairs_q, perf_pairs_d;
  logic [15:0] perf_redirects_q, perf_redirects_d;

  always_comb begin
    perf_pairs_d     = perf_pairs_q;
    perf_redirects_d = perf_redirects_q;
    if (pop && (perf_pairs_q != 16'hFFFF)) perf_pairs_d = perf_pairs_q + 16'd1;
    if (redirect && (perf_redirects_q != 16'hFFFF)) perf_redirects_d = perf_redirects_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_pairs_q     <= 16'd0;
      perf_redirects_q <= 16'd0;
    end else begin
      perf_pairs_q     <= perf_pairs_d;
      perf_redirects_q <= perf_redirects_d;
    end
  end

  assign perf_pairs     = perf_pairs_q;
  assign perf_redirects = perf_redirects_q;
`else
  // default build carries no performance counters
`endif

endmodule
